// File: rtl/bcd_opstack_pkg.sv
// Shared types and constants for the BCD operand stack: action encoding,
// seven-segment patterns and a BCD nibble check.
package bcd_opstack_pkg;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RESULT,
    ACT_ENTER,
    ACT_POP,
    ACT_BKSP,
    ACT_SIGN,
    ACT_STORE
  } action_e;

  localparam logic [7:0] SEG_DASH = 8'h40;

  // Index 0 is the rightmost element; segments are {dp,g,f,e,d,c,b,a}.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
    8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_ssdec.sv
// Combinational BCD nibble to seven-segment decoder; non-BCD shows a dash.
module bcd_ssdec
  import bcd_opstack_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (is_bcd_digit(bcd)) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/bcd_operand_stack.sv
// Signed BCD keypad entry register feeding a LIFO operand stack with ALU taps.
// Optional build macro BCD_OPSTACK_SCAN_EN replaces digit_sel with a scanned an output.
module bcd_operand_stack
  import bcd_opstack_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int DEPTH      = 4,
  localparam int W         = 4*NUM_DIGITS + 1,
  localparam int DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DPW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            digit,
  input  logic                  store_digit,
  input  logic                  backspace,
  input  logic                  toggle_sign,
  input  logic                  enter,
  input  logic                  pop,
  input  logic [W-1:0]          result,
  input  logic                  result_ready,
`ifdef BCD_OPSTACK_SCAN_EN
  output logic [NUM_DIGITS-1:0] an,
`else
  input  logic [DW-1:0]         digit_sel,
`endif
  output logic [W-1:0]          entry,
  output logic [W-1:0]          op1,
  output logic [W-1:0]          op2,
  output logic [DPW-1:0]        depth,
  output logic                  full,
  output logic                  empty,
  output logic                  err,
  output logic [7:0]            ssdec,
  output logic                  sign
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int MW = W - 1;

  logic [W-1:0]   entry_q, entry_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   stack_q [DEPTH];
  logic [W-1:0]   stack_d [DEPTH];
  logic [DPW-1:0] depth_q, depth_d;
  logic           err_q, err_d;

  action_e        act;
  logic           res_bcd;
  logic [MW-1:0]  mag_shl;
  logic [MW-1:0]  mag_shr;
  logic [DW-1:0]  sel;
  logic [3:0]     sel_nib;

  always_comb begin
    act = ACT_NONE;
    if (result_ready)     act = ACT_RESULT;
    else if (enter)       act = ACT_ENTER;
    else if (pop)         act = ACT_POP;
    else if (backspace)   act = ACT_BKSP;
    else if (toggle_sign) act = ACT_SIGN;
    else if (store_digit) act = ACT_STORE;
  end

  always_comb begin
    res_bcd = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd_digit(result[4*i +: 4])) res_bcd = 1'b0;
    end
  end

  // The top digit drops off the shift; a store only happens when it is zero.
  assign mag_shl = (entry_q[MW-1:0] << 4) | MW'(digit);
  assign mag_shr = entry_q[MW-1:0] >> 4;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    stack_d = stack_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    case (act)
      ACT_RESULT: begin
        entry_d = result;
        count_d = CW'(NUM_DIGITS);
        err_d   = !res_bcd;
      end
      ACT_ENTER: begin
        if (depth_q == DPW'(DEPTH)) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (DPW'(i) == depth_q) stack_d[i] = entry_q;
          end
          depth_d = depth_q + DPW'(1);
          entry_d = '0;
          count_d = '0;
        end
      end
      ACT_POP: begin
        if (depth_q == '0) err_d = 1'b1;
        else               depth_d = depth_q - DPW'(1);
      end
      ACT_BKSP: begin
        entry_d[MW-1:0] = mag_shr;
        if (mag_shr == '0) entry_d[MW] = 1'b0;
        if (count_q != '0) count_d = count_q - CW'(1);
      end
      ACT_SIGN: begin
        if (entry_q[MW-1:0] != '0) entry_d[MW] = ~entry_q[MW];
      end
      ACT_STORE: begin
        if (!is_bcd_digit(digit) || count_q == CW'(NUM_DIGITS)) begin
          err_d = 1'b1;
        end else if (!(count_q == '0 && digit == 4'd0)) begin
          entry_d[MW-1:0] = mag_shl;
          count_d         = count_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
      count_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  // Slots at or above depth are stale after a pop, so outputs are masked by depth.
  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DPW'(i + 1) == depth_q) op1 = stack_q[i];
      if (DPW'(i + 2) == depth_q) op2 = stack_q[i];
    end
  end

  assign entry = entry_q;
  assign sign  = entry_q[MW];
  assign depth = depth_q;
  assign full  = (depth_q == DPW'(DEPTH));
  assign empty = (depth_q == '0);
  assign err   = err_q;

`ifdef BCD_OPSTACK_SCAN_EN
  logic [15:0]           presc_q, presc_d;
  logic [DW-1:0]         scan_q, scan_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  always_comb begin
    presc_d = presc_q + 16'd1;
    scan_d  = scan_q;
    if (presc_q == 16'hFFFF) begin
      scan_d = (scan_q == DW'(NUM_DIGITS - 1)) ? '0 : scan_q + DW'(1);
    end
    for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (DW'(i) == scan_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      an_q    <= NUM_DIGITS'(1);
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
    end
  end

  assign an  = an_q;
  assign sel = scan_q;
`else
  assign sel = digit_sel;
`endif

  always_comb begin
    sel_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (DW'(i) == sel) sel_nib = entry_q[4*i +: 4];
    end
  end

  bcd_ssdec u_ssdec (
    .bcd (sel_nib),
    .seg (ssdec)
  );

endmodule
